// File: rtl/neuron_mac_sequencer_pkg.sv
// Shared types and arithmetic helpers for the neuron MAC datapath:
// state encoding, sign-magnitude weight decode and saturating accumulate.
package nn_pkg;

    localparam int WEIGHT_W  = 8;
    localparam int ACT_W     = 8;
    localparam int TERM_W    = WEIGHT_W + ACT_W;
    localparam int SAT_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [SAT_MAX_W-1:0] sum;
        logic                        ovf;
    } sat_t;

    // Negative zero (8'h80) decodes to 0, so it contributes nothing.
    function automatic logic signed [WEIGHT_W-1:0] sm_to_signed(
        input logic [WEIGHT_W-1:0] w
    );
        logic signed [WEIGHT_W-1:0] mag;
        mag = {1'b0, w[WEIGHT_W-2:0]};
        return w[WEIGHT_W-1] ? -mag : mag;
    endfunction

    // Adds at one extra bit and clamps into the signed range of acc_w bits.
    // Operands must already be sign-extended to SAT_MAX_W; acc_w <= SAT_MAX_W.
    function automatic sat_t sat_add(
        input logic signed [SAT_MAX_W-1:0] acc,
        input logic signed [SAT_MAX_W-1:0] term,
        input int                          acc_w
    );
        logic signed [SAT_MAX_W:0] s;
        logic signed [SAT_MAX_W:0] mx;
        logic signed [SAT_MAX_W:0] mn;
        sat_t                      r;
        s  = {acc[SAT_MAX_W-1], acc} + {term[SAT_MAX_W-1], term};
        mx = '0;
        mx[acc_w-1] = 1'b1;
        mx = mx - (SAT_MAX_W+1)'(1);
        mn = -mx - (SAT_MAX_W+1)'(1);
        r.ovf = 1'b0;
        r.sum = s[SAT_MAX_W-1:0];
        if (s > mx) begin
            r.sum = mx[SAT_MAX_W-1:0];
            r.ovf = 1'b1;
        end else if (s < mn) begin
            r.sum = mn[SAT_MAX_W-1:0];
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// Bundle between the sequencer and its surroundings: layer controller start,
// weight/activation read ports and the valid/ready result channel.
interface neuron_mac_sequencer_if #(
    parameter int SEL_W = 32,
    parameter int ACC_W = 20
);
    import nn_pkg::*;

    logic                      start_i;
    logic                      busy_o;
    logic [SEL_W-1:0]          w_sel_o;
    logic [WEIGHT_W-1:0]       w_data_i;
    logic [SEL_W-1:0]          x_sel_o;
    logic [ACT_W-1:0]          x_data_i;
    logic signed [ACC_W-1:0]   acc_o;
    logic                      res_valid_o;
    logic                      res_ready_i;
    logic                      overflow_o;

    modport master (
        input  start_i, w_data_i, x_data_i, res_ready_i,
        output busy_o, w_sel_o, x_sel_o, acc_o, res_valid_o, overflow_o
    );

    modport slave (
        output start_i, w_data_i, x_data_i, res_ready_i,
        input  busy_o, w_sel_o, x_sel_o, acc_o, res_valid_o, overflow_o
    );

endinterface

// File: rtl/neuron_mac_sequencer_sm_mult.sv
// Combinational sign-magnitude weight times unsigned activation, giving a
// signed product term (|term| <= 127*255, fits TERM_W).
module sm_mult
    import nn_pkg::*;
(
    input  logic [WEIGHT_W-1:0]      w_data,
    input  logic [ACT_W-1:0]         x_data,
    output logic signed [TERM_W-1:0] term
);

    logic signed [WEIGHT_W-1:0] w_s;
    logic signed [TERM_W-1:0]   w_ext;
    logic signed [TERM_W-1:0]   x_ext;

    assign w_s   = sm_to_signed(w_data);
    assign w_ext = TERM_W'(w_s);
    assign x_ext = TERM_W'({1'b0, x_data});
    assign term  = w_ext * x_ext;

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Sequences one neuron evaluation: walks index 0..N-1 over weight memory and
// activation buffer, saturating-accumulates the products, then holds the result.
module neuron_mac_sequencer
    import nn_pkg::*;
#(
    parameter int N     = 10,
    parameter int ACC_W = 20,
    parameter int SEL_W = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    neuron_mac_sequencer_if.master bus
);

    localparam int CNT_W = $clog2(N) + 1;

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    ovf_q;
    logic signed [TERM_W-1:0] term;
    sat_t                    sat_r;
    logic                    last_idx;
    logic                    busy;
    logic                    valid;
    logic [SEL_W-1:0]        sel;

    sm_mult u_mult (
        .w_data (bus.w_data_i),
        .x_data (bus.x_data_i),
        .term   (term)
    );

    assign last_idx = (cnt_q == CNT_W'(N - 1));
    assign sat_r    = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(term), ACC_W);

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        valid   = 1'b0;
        sel     = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                sel  = SEL_W'(cnt_q);
                if (last_idx) state_d = HOLD;
            end
            HOLD: begin
                // start_i is deliberately not looked at here: a new job needs IDLE.
                busy  = 1'b1;
                valid = 1'b1;
                if (bus.res_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Accumulate stage: one product per RUN cycle, clamped value carried forward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        cnt_q <= '0;
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q <= sat_r.sum[ACC_W-1:0];
                    ovf_q <= ovf_q | sat_r.ovf;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o      = busy;
    assign bus.res_valid_o = valid;
    assign bus.w_sel_o     = sel;
    assign bus.x_sel_o     = sel;
    assign bus.acc_o       = acc_q;
    assign bus.overflow_o  = ovf_q;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed plus randomized checks of neuron_mac_sequencer against a plain
// arithmetic reference of the saturating dot product.
module tb_neuron_mac_sequencer;
    import nn_pkg::*;

    localparam int N = 10;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] x_mem [2][N];
    logic       inj_en;
    int         inj_idx;
    logic [7:0] inj_val;

    neuron_mac_sequencer_if #(.SEL_W(32), .ACC_W(20)) if_a ();
    neuron_mac_sequencer_if #(.SEL_W(32), .ACC_W(12)) if_b ();

    neuron_mac_sequencer #(.N(N), .ACC_W(20), .SEL_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    neuron_mac_sequencer #(.N(N), .ACC_W(12), .SEL_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] wbyte(int i);
        if (inj_en && i == inj_idx) return inj_val;
        return (i % 3 == 0) ? 8'h82 : 8'h04;
    endfunction

    always_comb begin
        if_a.w_data_i = (if_a.w_sel_o < 32'd10) ? wbyte(int'(if_a.w_sel_o)) : 8'h00;
        if_a.x_data_i = (if_a.x_sel_o < 32'd10) ? x_mem[0][int'(if_a.x_sel_o)] : 8'h00;
        if_b.w_data_i = (if_b.w_sel_o < 32'd10) ? wbyte(int'(if_b.w_sel_o)) : 8'h00;
        if_b.x_data_i = (if_b.x_sel_o < 32'd10) ? x_mem[1][int'(if_b.x_sel_o)] : 8'h00;
    end

    function automatic void model(input int accw, input int which, output int sum, output bit ovf);
        int mx;
        int mn;
        mx  = (1 << (accw - 1)) - 1;
        mn  = -(1 << (accw - 1));
        sum = 0;
        ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            logic [7:0] w;
            int mag;
            w   = wbyte(i);
            mag = int'(w[6:0]);
            sum = sum + int'(x_mem[which][i]) * (w[7] ? -mag : mag);
            if (sum > mx) begin
                sum = mx;
                ovf = 1'b1;
            end else if (sum < mn) begin
                sum = mn;
                ovf = 1'b1;
            end
        end
    endfunction

    function automatic logic signed [63:0] acc_of(int which);
        logic signed [63:0] a;
        logic signed [63:0] b;
        a = 64'(if_a.acc_o);
        b = 64'(if_b.acc_o);
        return (which == 0) ? a : b;
    endfunction
    function automatic logic valid_of(int which);
        return (which == 0) ? if_a.res_valid_o : if_b.res_valid_o;
    endfunction
    function automatic logic busy_of(int which);
        return (which == 0) ? if_a.busy_o : if_b.busy_o;
    endfunction
    function automatic logic ovf_of(int which);
        return (which == 0) ? if_a.overflow_o : if_b.overflow_o;
    endfunction
    function automatic logic [31:0] wsel_of(int which);
        return (which == 0) ? if_a.w_sel_o : if_b.w_sel_o;
    endfunction
    function automatic logic [31:0] xsel_of(int which);
        return (which == 0) ? if_a.x_sel_o : if_b.x_sel_o;
    endfunction

    task automatic set_start(int which, logic v);
        if (which == 0) if_a.start_i = v;
        else            if_b.start_i = v;
    endtask
    task automatic set_ready(int which, logic v);
        if (which == 0) if_a.res_ready_i = v;
        else            if_b.res_ready_i = v;
    endtask
    task automatic set_x(int which, logic [7:0] v);
        for (int i = 0; i < N; i++) x_mem[which][i] = v;
    endtask

    task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(int which, string tag);
        check({tag, " busy"},  busy_of(which),  0);
        check({tag, " valid"}, valid_of(which), 0);
        check({tag, " ovf"},   ovf_of(which),   0);
        check({tag, " acc"},   acc_of(which),   0);
        check({tag, " wsel"},  wsel_of(which),  0);
        check({tag, " xsel"},  xsel_of(which),  0);
    endtask

    // Starts a job, waits for the result, checks it and completes the handshake.
    task automatic run_job(int which, string tag, int ready_delay);
        int   exp_sum;
        bit   exp_ovf;
        int   cyc;
        int   sels[$];
        bit   sel_match;
        bit   stable;
        logic signed [63:0] acc0;
        model((which == 0) ? 20 : 12, which, exp_sum, exp_ovf);
        sel_match = 1'b1;
        @(negedge clk);
        set_start(which, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            set_start(which, 1'b0);
            cyc++;
            if (busy_of(which) && !valid_of(which)) begin
                sels.push_back(int'(wsel_of(which)));
                if (xsel_of(which) !== wsel_of(which)) sel_match = 1'b0;
            end
        end while (!valid_of(which) && cyc < 40);
        check({tag, " latency"}, cyc, N + 1);
        check({tag, " acc"}, acc_of(which), exp_sum);
        check({tag, " ovf"}, ovf_of(which), exp_ovf);
        check({tag, " run cycles"}, sels.size(), N);
        for (int i = 0; i < sels.size(); i++)
            if (sels[i] != i) sel_match = 1'b0;
        check({tag, " sel sequence"}, sel_match, 1);
        acc0   = acc_of(which);
        stable = 1'b1;
        repeat (ready_delay) begin
            @(negedge clk);
            if (valid_of(which) !== 1'b1 || acc_of(which) !== acc0) stable = 1'b0;
        end
        check({tag, " hold stable"}, stable, 1);
        set_ready(which, 1'b1);
        @(negedge clk);
        set_ready(which, 1'b0);
        check({tag, " valid after ack"}, valid_of(which), 0);
        check({tag, " busy after ack"},  busy_of(which),  0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cyc;
        rst_n = 1'b0;
        if_a.start_i = 1'b0; if_a.res_ready_i = 1'b0;
        if_b.start_i = 1'b0; if_b.res_ready_i = 1'b0;
        inj_en = 1'b0; inj_idx = 0; inj_val = 8'h00;
        set_x(0, 8'd0);
        set_x(1, 8'd0);
        repeat (3) @(negedge clk);
        check_idle_zero(0, "reset a");
        check_idle_zero(1, "reset b");
        rst_n = 1'b1;

        // all activations 1
        set_x(0, 8'd1);
        run_job(0, "t1", 0);

        // single non-zero activation
        set_x(0, 8'd0);
        x_mem[0][0] = 8'd100;
        run_job(0, "t2", 1);

        // saturation on a narrow accumulator, then sticky flag cleared
        set_x(1, 8'd255);
        run_job(1, "t3 sat", 0);
        set_x(1, 8'd1);
        run_job(1, "t3 clear", 0);

        // backpressure with a start pulse during HOLD
        set_x(0, 8'd1);
        @(negedge clk);
        set_start(0, 1'b1);
        wait_cyc = 0;
        do begin
            @(negedge clk);
            set_start(0, 1'b0);
            wait_cyc++;
        end while (!valid_of(0) && wait_cyc < 40);
        check("t4 latency", wait_cyc, N + 1);
        for (int k = 0; k < 5; k++) begin
            set_start(0, (k == 2) ? 1'b1 : 1'b0);
            @(negedge clk);
            check("t4 valid held", valid_of(0), 1);
            check("t4 acc held", acc_of(0), 16);
        end
        set_start(0, 1'b1);
        set_ready(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        set_ready(0, 1'b0);
        check("t4 valid after ack", valid_of(0), 0);
        check("t4 busy after ack", busy_of(0), 0);
        @(negedge clk);
        check("t4 no queued job", busy_of(0), 0);

        // reset in the middle of RUN
        @(negedge clk);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (4) @(negedge clk);
        check("t5 index before reset", wsel_of(0), 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_zero(0, "t5 after reset");
        run_job(0, "t5 fresh", 0);

        // negative-zero weight contributes nothing
        inj_en  = 1'b1;
        inj_idx = 1;
        inj_val = 8'h80;
        run_job(0, "t6", 0);
        inj_en = 1'b0;

        // randomized activations and injected weights on both widths
        for (int r = 0; r < 10; r++) begin
            int which;
            which = r % 2;
            for (int i = 0; i < N; i++) x_mem[which][i] = 8'($urandom);
            inj_en  = 1'($urandom_range(0, 1));
            inj_idx = int'($urandom_range(0, N - 1));
            inj_val = 8'($urandom);
            run_job(which, "rand", int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
